// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a split addr_ok/data_ok
// SRAM interface and produces the writeback value and the load-use pending flag.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_to_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_res_from_mem,
  input  logic        ex_mem_we,
  input  logic [2:0]  ex_mem_op,
  input  logic [31:0] ex_rkd_value,
  input  logic [5:0]  ex_rf_zip,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [5:0]  mem_rf_zip,
  output logic [31:0] mem_final_result,
  output logic        mem_ld_pending,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        r_valid;
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_alu;
  logic [31:0] r_rkd;
  logic [31:0] r_buf;
  logic        r_ld;
  logic        r_st;
  logic [2:0]  r_op;
  logic [5:0]  r_zip;

  logic        w_is_mem;
  logic        w_ready_go;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_is_mem        = r_ld | r_st;
  assign w_ready_go      = ~w_is_mem | (r_state == S_DONE);
  assign mem_allowin     = ~r_valid | (w_ready_go & wb_allowin);
  assign mem_to_wb_valid = r_valid & w_ready_go;
  assign w_accept        = ex_to_mem_valid & mem_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_alu   <= '0;
      r_rkd   <= '0;
      r_buf   <= '0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_op    <= '0;
      r_zip   <= '0;
    end else begin
      if (mem_allowin) r_valid <= ex_to_mem_valid;
      if (w_accept) begin
        r_pc  <= ex_pc;
        r_alu <= ex_alu_result;
        r_rkd <= ex_rkd_value;
        r_ld  <= ex_res_from_mem;
        r_st  <= ex_mem_we;
        r_op  <= ex_mem_op;
        r_zip <= ex_rf_zip;
      end
      // A new accept always restarts the FSM, which also covers draining DONE.
      if (w_accept) begin
        r_state <= (ex_res_from_mem | ex_mem_we) ? S_REQ : S_IDLE;
      end else begin
        case (r_state)
          S_REQ:   if (data_sram_addr_ok) r_state <= S_WAIT;
          S_WAIT:  if (data_sram_data_ok) r_state <= S_DONE;
          S_DONE:  if (mem_to_wb_valid & wb_allowin) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
      if ((r_state == S_WAIT) && data_sram_data_ok) r_buf <= data_sram_rdata;
    end
  end

  always_comb begin
    w_byte = r_buf[7:0];
    case (r_alu[1:0])
      2'd1:    w_byte = r_buf[15:8];
      2'd2:    w_byte = r_buf[23:16];
      2'd3:    w_byte = r_buf[31:24];
      default: w_byte = r_buf[7:0];
    endcase
    w_half = r_alu[1] ? r_buf[31:16] : r_buf[15:0];
    case (r_op[1:0])
      2'b00:   w_load_data = {{24{w_byte[7] & ~r_op[2]}}, w_byte};
      2'b01:   w_load_data = {{16{w_half[15] & ~r_op[2]}}, w_half};
      default: w_load_data = r_buf;
    endcase
  end

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = r_rkd;
    case (r_op[1:0])
      2'b00: begin
        data_sram_wstrb = 4'b0001 << r_alu[1:0];
        data_sram_wdata = {4{r_rkd[7:0]}};
      end
      2'b01: begin
        data_sram_wstrb = r_alu[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{r_rkd[15:0]}};
      end
      default: data_sram_wstrb = 4'b1111;
    endcase
    if (!r_st) data_sram_wstrb = 4'b0000;
  end

  assign data_sram_req    = (r_state == S_REQ);
  assign data_sram_wr     = r_st;
  assign data_sram_size   = r_op[1:0];
  assign data_sram_addr   = r_alu;
  assign mem_pc           = r_pc;
  assign mem_rf_zip       = r_zip;
  assign mem_final_result = r_ld ? w_load_data : r_alu;
  assign mem_ld_pending   = r_valid & r_ld & (r_state != S_DONE);

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model of the stage plus an
// SRAM slave with random addr_ok/data_ok timing, stray responses and resets.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_to_mem_valid, mem_allowin;
  logic [31:0] ex_pc, ex_alu_result, ex_rkd_value;
  logic        ex_res_from_mem, ex_mem_we;
  logic [2:0]  ex_mem_op;
  logic [5:0]  ex_rf_zip;
  logic        wb_allowin, mem_to_wb_valid;
  logic [31:0] mem_pc, mem_final_result;
  logic [5:0]  mem_rf_zip;
  logic        mem_ld_pending;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
    .ex_res_from_mem(ex_res_from_mem), .ex_mem_we(ex_mem_we),
    .ex_mem_op(ex_mem_op), .ex_rkd_value(ex_rkd_value), .ex_rf_zip(ex_rf_zip),
    .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid),
    .mem_pc(mem_pc), .mem_rf_zip(mem_rf_zip),
    .mem_final_result(mem_final_result), .mem_ld_pending(mem_ld_pending),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [2:0] op);
    logic [31:0] v;
    if (op[1:0] == 2'd0) begin
      v = (rd >> (8 * a[1:0])) & 32'hFF;
      if (!op[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (op[1:0] == 2'd1) begin
      v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (!op[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_wstrb(input logic [31:0] a, input logic [2:0] op);
    if (op[1:0] == 2'd0) return 32'd1 << a[1:0];
    if (op[1:0] == 2'd1) return a[1] ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [31:0] d, input logic [2:0] op);
    if (op[1:0] == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (op[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // Directed opening: add, ld.w, ld.b, ld.hu, st.h
  logic [31:0] d_pc  [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
  logic [31:0] d_alu [5] = '{32'h10, 32'h1000, 32'h1003, 32'h1002, 32'h2002};
  logic        d_ld  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        d_st  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0]  d_op  [5] = '{3'b010, 3'b010, 3'b000, 3'b101, 3'b001};
  logic [31:0] d_rkd [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678};
  logic [5:0]  d_zip [5] = '{6'h25, 6'h21, 6'h22, 6'h23, 6'h00};
  logic [31:0] d_rd  [5] = '{32'h0, 32'hDEADBEEF, 32'h80FF0000, 32'h80FF0000, 32'h0};

  // transaction held by the stage
  logic        m_v, m_ld, m_st, m_at, m_dg;
  logic [31:0] m_pc, m_alu, m_rkd, m_rd;
  logic [2:0]  m_op;
  logic [5:0]  m_zip;
  int unsigned m_cnt, m_idx, m_tid;
  // inputs applied at the previous edge
  logic        p_reset, p_exv, p_wb, p_aok, p_dok, p_allow, p_ld, p_st;
  logic [31:0] p_pc, p_alu, p_rkd, p_rdata;
  logic [2:0]  p_op;
  logic [5:0]  p_zip;
  logic        old_ready, drained, accept, waiting, mem_op, rst_done, force_stray;
  logic        e_ready, e_allow, e_valid, e_req, e_pend;

  initial begin
    reset = 1'b1; ex_to_mem_valid = 1'b0; ex_pc = '0; ex_alu_result = '0;
    ex_res_from_mem = 1'b0; ex_mem_we = 1'b0; ex_mem_op = '0; ex_rkd_value = '0;
    ex_rf_zip = '0; wb_allowin = 1'b0; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 32'(mem_to_wb_valid), 32'd0);
      chk("rst_req", 32'(data_sram_req), 32'd0);
      chk("rst_pend", 32'(mem_ld_pending), 32'd0);
      chk("rst_allowin", 32'(mem_allowin), 32'd1);
      chk("rst_result", mem_final_result, 32'd0);
      chk("rst_addr", data_sram_addr, 32'd0);
    end
    reset = 1'b0;
    m_v = 0; m_ld = 0; m_st = 0; m_at = 0; m_dg = 0; m_cnt = 0; m_idx = 0; m_tid = 0;
    m_pc = '0; m_alu = '0; m_rkd = '0; m_rd = '0; m_op = '0; m_zip = '0;
    p_reset = 0; p_exv = 0; p_wb = 0; p_aok = 0; p_dok = 0; p_allow = 1;
    p_ld = 0; p_st = 0; p_pc = '0; p_alu = '0; p_rkd = '0; p_rdata = '0; p_op = '0; p_zip = '0;
    rst_done = 0; force_stray = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // account for the edge that just happened
      if (p_reset) begin
        m_v = 0; m_at = 0; m_dg = 0;
      end else begin
        old_ready = !(m_ld | m_st) | m_dg;
        drained = m_v & old_ready & p_wb;
        accept = p_exv & p_allow;
        if (m_v && (m_ld || m_st) && !m_dg) begin
          if (!m_at) begin
            if (p_aok) begin m_at = 1; m_cnt = $urandom_range(0, 3); end
          end else if (p_dok) begin
            m_dg = 1; m_rd = p_rdata;
          end
        end
        if (drained) m_v = 0;
        if (accept) begin
          m_v = 1; m_pc = p_pc; m_alu = p_alu; m_rkd = p_rkd; m_ld = p_ld; m_st = p_st;
          m_op = p_op; m_zip = p_zip; m_at = 0; m_dg = 0; m_tid = m_idx; m_idx++;
        end
      end

      // choose inputs for the next edge
      mem_op = m_v & (m_ld | m_st);
      waiting = mem_op & m_at & !m_dg;
      if (m_idx < 5) begin
        p_exv = 1; p_pc = d_pc[m_idx]; p_alu = d_alu[m_idx]; p_ld = d_ld[m_idx];
        p_st = d_st[m_idx]; p_op = d_op[m_idx]; p_rkd = d_rkd[m_idx]; p_zip = d_zip[m_idx];
      end else begin
        int unsigned typ;
        typ = $urandom_range(0, 2);
        p_exv = ($urandom_range(0, 9) < 7);
        p_pc = $urandom; p_alu = $urandom; p_rkd = $urandom; p_zip = 6'($urandom);
        p_ld = (typ == 1); p_st = (typ == 2);
        p_op = 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 2));
      end
      p_wb = ($urandom_range(0, 9) < 7);
      if (mem_op && !m_at) p_aok = ($urandom_range(0, 9) < 4);
      else p_aok = ($urandom_range(0, 19) == 0);
      p_rdata = $urandom;
      if (waiting) begin
        if (m_cnt == 0) begin
          p_dok = 1;
          if (m_tid < 5) p_rdata = d_rd[m_tid];
        end else begin
          m_cnt--; p_dok = 0;
        end
      end else if (!mem_op || m_dg) begin
        p_dok = force_stray || ($urandom_range(0, 19) == 0);
      end else begin
        p_dok = 0;
      end
      force_stray = 0;
      p_reset = 0;
      if (!rst_done && cyc > 1000 && waiting) begin
        p_reset = 1; rst_done = 1; force_stray = 1;
      end else if (m_idx > 5 && $urandom_range(0, 299) == 0) begin
        p_reset = 1;
      end

      reset = p_reset; ex_to_mem_valid = p_exv; ex_pc = p_pc; ex_alu_result = p_alu;
      ex_res_from_mem = p_ld; ex_mem_we = p_st; ex_mem_op = p_op; ex_rkd_value = p_rkd;
      ex_rf_zip = p_zip; wb_allowin = p_wb; data_sram_addr_ok = p_aok;
      data_sram_data_ok = p_dok; data_sram_rdata = p_rdata;
      #1;

      e_ready = !(m_ld | m_st) | m_dg;
      e_allow = !m_v | (e_ready & p_wb);
      e_valid = m_v & e_ready;
      e_req = mem_op & !m_at;
      e_pend = m_v & m_ld & !m_dg;
      p_allow = e_allow;
      chk("allowin", 32'(mem_allowin), 32'(e_allow));
      chk("to_wb_valid", 32'(mem_to_wb_valid), 32'(e_valid));
      chk("sram_req", 32'(data_sram_req), 32'(e_req));
      chk("ld_pending", 32'(mem_ld_pending), 32'(e_pend));
      if (e_req) begin
        chk("req_addr", data_sram_addr, m_alu);
        chk("req_wr", 32'(data_sram_wr), 32'(m_st));
        chk("req_size", 32'(data_sram_size), 32'(m_op[1:0]));
        chk("req_wstrb", 32'(data_sram_wstrb), m_st ? f_wstrb(m_alu, m_op) : 32'd0);
        if (m_st) chk("req_wdata", data_sram_wdata, f_wdata(m_rkd, m_op));
      end
      if (e_valid) begin
        chk("wb_pc", mem_pc, m_pc);
        chk("wb_zip", 32'(mem_rf_zip), 32'(m_zip));
        chk("wb_result", mem_final_result, m_ld ? f_load(m_rd, m_alu, m_op) : m_alu);
      end
    end
    chk("directed_ops_issued", 32'(m_idx >= 5), 32'd1);
    chk("reset_in_wait_hit", 32'(rst_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
